// File: rtl/hilo_muldiv.sv
// hilo_muldiv: multi-cycle MULT/MULTU/DIV/DIVU unit feeding the HI/LO register.
// Ports: clk, reset (async, active-high); start/op/src_a/src_b/cancel from EX;
//        busy (stall request), hilo_wen (one-cycle pulse), hilo_result {hi, lo}.
// Optional macro HILO_MUL_SINGLE_CYCLE_EN: multiplies use the synthesized
//        multiplier and finish in one cycle instead of the 32-step CALC path.
module hilo_muldiv #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        cancel,
  output logic        busy,
  output logic        hilo_wen,
  output logic [63:0] hilo_result
);

  localparam logic [4:0] CNT_LAST = 5'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  logic        neg_lo_q, neg_lo_d;   // negate product / quotient at the end
  logic        neg_hi_q, neg_hi_d;   // negate remainder at the end (divide only)
  logic [31:0] hi_q, hi_d;           // partial product high / partial remainder
  logic [31:0] lo_q, lo_d;           // multiplier bits / dividend-then-quotient bits
  logic [31:0] b_q, b_d;             // multiplicand or divisor magnitude
  logic [63:0] result_q, result_d;

  // Operand magnitudes and sign flags for the accept cycle.
  logic        signed_op;
  logic [31:0] a_mag, b_mag;

  // One radix-2 step of either algorithm.
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [32:0] div_diff;
  logic [31:0] step_hi, step_lo;
  logic [63:0] mul_prod;
  logic [31:0] fix_hi, fix_lo;

`ifdef HILO_MUL_SINGLE_CYCLE_EN
  logic [63:0] fast_prod;
  always_comb begin
    if (op[0]) begin
      fast_prod = {32'd0, src_a} * {32'd0, src_b};
    end else begin
      // Sign-extended operands give the correct two's complement product mod 2^64.
      fast_prod = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
    end
  end
`endif

  always_comb begin
    signed_op = ~op[0];
    a_mag     = (signed_op && src_a[31]) ? (32'd0 - src_a) : src_a;
    b_mag     = (signed_op && src_b[31]) ? (32'd0 - src_b) : src_b;
  end

  always_comb begin
    // Shift-add: add multiplicand when the current multiplier bit is set,
    // then shift the 65-bit {carry, hi, lo} right by one.
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : 33'd0);
    // Restoring divide: shift next dividend bit into the remainder, try subtract.
    div_shift = {hi_q, lo_q[31]};
    div_diff  = div_shift - {1'b0, b_q};
    if (is_div_q) begin
      if (!div_diff[32]) begin
        step_hi = div_diff[31:0];
        step_lo = {lo_q[30:0], 1'b1};
      end else begin
        step_hi = div_shift[31:0];
        step_lo = {lo_q[30:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[32:1];
      step_lo = {mul_sum[0], lo_q[31:1]};
    end
    mul_prod = neg_lo_q ? (64'd0 - {step_hi, step_lo}) : {step_hi, step_lo};
    fix_hi   = neg_hi_q ? (32'd0 - step_hi) : step_hi;
    fix_lo   = neg_lo_q ? (32'd0 - step_lo) : step_lo;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    b_d      = b_q;
    result_d = result_q;

    case (state_q)
      IDLE: begin
        if (start && !cancel) begin
          is_div_d = op[1];
          neg_lo_d = signed_op & (src_a[31] ^ src_b[31]);
          neg_hi_d = signed_op & src_a[31];
          cnt_d    = 5'd0;
          hi_d     = 32'd0;
          if (op[1]) begin
            lo_d = a_mag;
            b_d  = b_mag;
          end else begin
            lo_d = b_mag;
            b_d  = a_mag;
          end
          if (op[1] && (src_b == 32'd0)) begin
            result_d = {src_a, 32'hFFFF_FFFF};
            state_d  = DONE;
`ifdef HILO_MUL_SINGLE_CYCLE_EN
          end else if (!op[1]) begin
            result_d = fast_prod;
            state_d  = DONE;
`endif
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (cancel) begin
          state_d = IDLE;
        end else begin
          hi_d  = step_hi;
          lo_d  = step_lo;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == CNT_LAST) begin
            result_d = is_div_q ? {fix_hi, fix_lo} : mul_prod;
            state_d  = DONE;
          end
        end
      end
      DONE: begin
        // start is ignored here so the stalled instruction is not re-accepted.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      b_q      <= 32'd0;
      result_q <= 64'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  // busy drops in DONE so the stall releases on the edge that writes HI/LO.
  assign busy        = ((state_q == IDLE) && start && !cancel) || (state_q == CALC);
  assign hilo_wen    = (state_q == DONE) && !cancel;
  assign hilo_result = result_q;

endmodule
